// File: rtl/di_par_loader.sv
// di_par_loader: buffers a checksummed parameter frame and writes it into the per-channel
// parameter space. Define DI_PAR_VERIFY_EN to add readback compare after the writes.
module di_par_loader #(
   parameter int unsigned CH_NUM    = 32,
   parameter int unsigned PAR_BYTES = 8,
   parameter int unsigned CH_STRIDE = 64,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_frm_vld,
   input  logic        i_frm_sop,
   input  logic [7:0]  im_frm_data,
   output logic        o_frm_rdy,
   output logic        o_parwren,
   output logic [11:0] om_paraddr,
   output logic [7:0]  om_pardata,
   output logic        o_rdren,
   output logic [11:0] om_rdaddr,
   input  logic [7:0]  im_rddata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err_cks,
   output logic        o_err_len,
   output logic        o_err_vfy,
   output logic [7:0]  om_err_cnt
);

   localparam int unsigned N      = CH_NUM * PAR_BYTES;
   localparam int unsigned CNT_W  = $clog2(N + 1);
   localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE, S_RECV, S_CHECK, S_WRITE, S_VERIFY, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   sum_q, sum_d;
   logic                err_cks_q, err_cks_d;
   logic                err_len_q, err_len_d;
   logic                err_vfy_q, err_vfy_d;
   logic [7:0]          err_cnt_q, err_cnt_d;
   logic                frm_rdy_q, frm_rdy_d;
   logic                parwren_q, parwren_d;
   logic [ADDR_W-1:0]   paraddr_q, paraddr_d;
   logic [DATA_W-1:0]   pardata_q, pardata_d;
   logic                rdren_q, rdren_d;
   logic [ADDR_W-1:0]   rdaddr_q, rdaddr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [DATA_W-1:0]   par_buf [N];
   logic                buf_we;
   logic [IDX_W-1:0]    buf_wa;
   logic                acc;

   assign acc = i_frm_vld && frm_rdy_q;

   // Flat byte index -> channel base + offset, truncated to the bus width
   function automatic logic [ADDR_W-1:0] idx2addr(input logic [CNT_W-1:0] idx);
      logic [31:0] ch;
      logic [31:0] off;
      ch  = 32'(idx) / PAR_BYTES;
      off = 32'(idx) % PAR_BYTES;
      return ADDR_W'(ch * CH_STRIDE + off);
   endfunction

`ifdef DI_PAR_VERIFY_EN
   logic [RD_LAT-1:0]   pipe_vld_q;
   logic [IDX_W-1:0]    pipe_idx_q [RD_LAT];
   logic                cmp_vld;
   logic [IDX_W-1:0]    cmp_idx;
   logic                cmp_bad;

   // Strobe/index delay line so each readback sample meets its own buffer byte
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pipe_vld_q <= '0;
      end else begin
         pipe_vld_q[0] <= rdren_q;
         for (int k = 1; k < RD_LAT; k++) pipe_vld_q[k] <= pipe_vld_q[k-1];
      end
   end

   always_ff @(posedge i_clk) begin
      pipe_idx_q[0] <= IDX_W'(cnt_q);
      for (int k = 1; k < RD_LAT; k++) pipe_idx_q[k] <= pipe_idx_q[k-1];
   end

   assign cmp_vld = pipe_vld_q[RD_LAT-1];
   assign cmp_idx = pipe_idx_q[RD_LAT-1];
   assign cmp_bad = cmp_vld && (im_rddata != par_buf[cmp_idx]);
`else
   logic unused_rd;
   assign unused_rd = ^{im_rddata, 8'(RD_LAT)};
`endif

   always_ff @(posedge i_clk) begin
      if (buf_we) par_buf[buf_wa] <= im_frm_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         sum_q     <= '0;
         err_cks_q <= 1'b0;
         err_len_q <= 1'b0;
         err_vfy_q <= 1'b0;
         err_cnt_q <= '0;
         frm_rdy_q <= 1'b0;
         parwren_q <= 1'b0;
         paraddr_q <= '0;
         pardata_q <= '0;
         rdren_q   <= 1'b0;
         rdaddr_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         err_cks_q <= err_cks_d;
         err_len_q <= err_len_d;
         err_vfy_q <= err_vfy_d;
         err_cnt_q <= err_cnt_d;
         frm_rdy_q <= frm_rdy_d;
         parwren_q <= parwren_d;
         paraddr_q <= paraddr_d;
         pardata_q <= pardata_d;
         rdren_q   <= rdren_d;
         rdaddr_q  <= rdaddr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Outputs are registered from next state/count, so they line up with the state they describe
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      err_cks_d = err_cks_q;
      err_len_d = err_len_q;
      err_vfy_d = err_vfy_q;
      err_cnt_d = err_cnt_q;
      buf_we    = 1'b0;
      buf_wa    = '0;

      unique case (state_q)
         S_IDLE, S_RECV: begin
            if (acc && i_frm_sop) begin
               buf_we    = 1'b1;
               sum_d     = im_frm_data;
               cnt_d     = CNT_W'(1);
               err_cks_d = 1'b0;
               err_len_d = (state_q == S_RECV);
               err_vfy_d = 1'b0;
               err_cnt_d = '0;
               state_d   = S_RECV;
            end else if (acc && (state_q == S_RECV)) begin
               buf_we = (cnt_q < CNT_W'(N));
               buf_wa = IDX_W'(cnt_q);
               sum_d  = sum_q + im_frm_data;
               if (cnt_q == CNT_W'(N)) state_d = S_CHECK;
               else                    cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         S_CHECK: begin
            cnt_d = '0;
            if (sum_q == '0) begin
               state_d = S_WRITE;
            end else begin
               err_cks_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_WRITE: begin
            if (cnt_q == CNT_W'(N - 1)) begin
               cnt_d = '0;
`ifdef DI_PAR_VERIFY_EN
               state_d = S_VERIFY;
`else
               state_d = S_DONE;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef DI_PAR_VERIFY_EN
         S_VERIFY: begin
            if (cnt_q < CNT_W'(N)) cnt_d = cnt_q + CNT_W'(1);
            if (cmp_bad) begin
               err_vfy_d = 1'b1;
               if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
            if (cmp_vld && (cmp_idx == IDX_W'(N - 1))) state_d = S_DONE;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      frm_rdy_d = (state_d == S_IDLE) || (state_d == S_RECV);
      busy_d    = !frm_rdy_d;
      done_d    = (state_d == S_DONE);
      parwren_d = (state_d == S_WRITE);
      paraddr_d = parwren_d ? idx2addr(cnt_d) : '0;
      pardata_d = parwren_d ? par_buf[IDX_W'(cnt_d)] : '0;
      rdren_d   = (state_d == S_VERIFY) && (cnt_d < CNT_W'(N));
      rdaddr_d  = rdren_d ? idx2addr(cnt_d) : '0;
   end

   assign o_frm_rdy  = frm_rdy_q;
   assign o_parwren  = parwren_q;
   assign om_paraddr = paraddr_q;
   assign om_pardata = pardata_q;
   assign o_rdren    = rdren_q;
   assign om_rdaddr  = rdaddr_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_err_cks  = err_cks_q;
   assign o_err_len  = err_len_q;
   assign o_err_vfy  = err_vfy_q;
   assign om_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_di_par_loader.sv
// Directed bench for di_par_loader: four instances with RD_LAT 1..4 share one frame stream;
// instance 0 is the reference for write/timing checks.
`timescale 1ns/1ps
module tb_di_par_loader;

   localparam int N = 256;
`ifdef DI_PAR_VERIFY_EN
   localparam int VFY = 1;
`else
   localparam int VFY = 0;
`endif

   logic clk;
   logic rst_n;
   logic frm_vld;
   logic frm_sop;
   logic [7:0] frm_data;
   logic flip_en;

   logic [3:0] rdy, wren, rden, busy, done, ecks, elen, evfy;
   logic [3:0][11:0] paddr, raddr;
   logic [3:0][7:0]  pdata, rdata, ecnt;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      logic [7:0] mem [4096];
      logic [7:0] rd_pipe [g+1];

      di_par_loader #(.RD_LAT(g + 1)) u_dut (
         .i_clk      (clk),
         .i_rst_n    (rst_n),
         .i_frm_vld  (frm_vld),
         .i_frm_sop  (frm_sop),
         .im_frm_data(frm_data),
         .o_frm_rdy  (rdy[g]),
         .o_parwren  (wren[g]),
         .om_paraddr (paddr[g]),
         .om_pardata (pdata[g]),
         .o_rdren    (rden[g]),
         .om_rdaddr  (raddr[g]),
         .im_rddata  (rdata[g]),
         .o_busy     (busy[g]),
         .o_done     (done[g]),
         .o_err_cks  (ecks[g]),
         .o_err_len  (elen[g]),
         .o_err_vfy  (evfy[g]),
         .om_err_cnt (ecnt[g])
      );

      // Parameter space model with fixed readback latency and an optional bit flip at 0x0C2
      always @(posedge clk) begin
         if (wren[g]) mem[paddr[g]] <= pdata[g];
         rd_pipe[0] <= mem[raddr[g]] ^ ((flip_en && raddr[g] == 12'h0C2) ? 8'h01 : 8'h00);
         for (int k = 1; k < g + 1; k++) rd_pipe[k] <= rd_pipe[k-1];
      end
      assign rdata[g] = rd_pipe[g];
   end

   logic [11:0] wr_addr_log [8192];
   logic [7:0]  wr_data_log [8192];
   int          wr_cyc_log  [8192];
   int          done_log    [64];
   int          wr_n = 0;
   int          rd_n = 0;
   int          ovl_n = 0;
   int          done_n [4] = '{0, 0, 0, 0};
   int          done_cyc [4] = '{0, 0, 0, 0};

   always @(negedge clk) begin
      if (wren[0]) begin
         wr_addr_log[wr_n] <= paddr[0];
         wr_data_log[wr_n] <= pdata[0];
         wr_cyc_log[wr_n]  <= cyc;
         wr_n <= wr_n + 1;
      end
      if (rden[0]) rd_n <= rd_n + 1;
      if (wren[0] && rden[0]) ovl_n <= ovl_n + 1;
      if (done[0]) done_log[done_n[0] % 64] <= cyc;
      for (int k = 0; k < 4; k++) begin
         if (done[k]) begin
            done_n[k]   <= done_n[k] + 1;
            done_cyc[k] <= cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   function automatic logic [7:0] pay(input int i);
      return 8'(i) ^ 8'h5A;
   endfunction

   function automatic logic [11:0] exp_addr(input int j);
      return 12'((j / 8) * 64 + (j % 8));
   endfunction

   function automatic logic [7:0] good_cks();
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < N; i++) s = s + pay(i);
      return 8'h00 - s;
   endfunction

   int last_acc;
   int first_acc;

   task automatic send_byte(input logic [7:0] d, input logic s);
      int w;
      w = 0;
      frm_vld = 1'b1; frm_sop = s; frm_data = d;
      while (!rdy[0] && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 3000) chk("rdy_timeout", 32'(w), 32'(0));
      last_acc = cyc;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] cks_delta, input int first, output int t_last);
      for (int i = first; i <= N; i++) begin
         send_byte((i < N) ? pay(i) : good_cks() + cks_delta, i == 0);
         if (i == first) first_acc = last_acc;
      end
      t_last = last_acc;
   endtask

   task automatic wait_done(input int k, input int base, input string tag);
      int w;
      w = 0;
      while (done_n[k] <= base && w < 5000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 5000) chk(tag, 32'(w), 32'(0));
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      frm_vld = 1'b0; frm_sop = 1'b0; rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   function automatic int count_bad(input int base, input int cnt);
      int bad;
      bad = 0;
      for (int j = 0; j < cnt; j++)
         if (wr_addr_log[base + j] !== exp_addr(j % N) || wr_data_log[base + j] !== pay(j % N))
            bad++;
      return bad;
   endfunction

   initial begin
      int t, tb2, bw, bd, wc;
      int bdk [4];
      rst_n = 1'b0; frm_vld = 1'b0; frm_sop = 1'b0; frm_data = 8'h00; flip_en = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rdy", 32'(rdy[0]), 0);
      chk("rst_wren", 32'(wren[0]), 0);
      chk("rst_busy", 32'(busy[0]), 0);
      chk("rst_done", 32'(done[0]), 0);
      chk("rst_flags", 32'({ecks[0], elen[0], evfy[0]}), 0);
      chk("rst_ecnt", 32'(ecnt[0]), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rdy_rel", 32'(rdy[0]), 1);

      // Good frame
      bw = wr_n; bd = done_n[0];
      send_frame(8'h00, 0, t);
      frm_vld = 1'b0;
      wait_done(0, bd, "t1_timeout");
      chk("t1_wr_cnt", 32'(wr_n - bw), 256);
      chk("t1_first_wr", 32'(wr_cyc_log[bw] - t), 2);
      chk("t1_last_wr", 32'(wr_cyc_log[bw + 255] - t), N + 1);
      chk("t1_addr9", 32'(wr_addr_log[bw + 9]), 32'h041);
      chk("t1_data9", 32'(wr_data_log[bw + 9]), 32'h53);
      chk("t1_addr255", 32'(wr_addr_log[bw + 255]), 32'h7C7);
      chk("t1_data255", 32'(wr_data_log[bw + 255]), 32'hA5);
      chk("t1_all_wr", 32'(count_bad(bw, 256)), 0);
      chk("t1_done_cyc", 32'(done_cyc[0] - t), VFY ? 2 * N + 3 : N + 2);
      chk("t1_rd_cnt", 32'(rd_n), VFY ? 256 : 0);
      chk("t1_flags", 32'({ecks[0], elen[0], evfy[0]}), 0);
      chk("t1_ecnt", 32'(ecnt[0]), 0);

      // Checksum failure
      do_reset();
      bw = wr_n; bd = done_n[0];
      send_frame(8'h01, 0, t);
      frm_vld = 1'b0;
      wait_done(0, bd, "t2_timeout");
      chk("t2_err_cks", 32'(ecks[0]), 1);
      chk("t2_wr_cnt", 32'(wr_n - bw), 0);
      chk("t2_done_cyc", 32'(done_cyc[0] - t), 2);
      chk("t2_err_len", 32'(elen[0]), 0);

      // Short frame restarted by a new SOP
      do_reset();
      for (int i = 0; i < 100; i++) send_byte(pay(i), i == 0);
      chk("t3_len_pre", 32'(elen[0]), 0);
      bw = wr_n; bd = done_n[0];
      send_byte(pay(0), 1'b1);
      chk("t3_len_set", 32'(elen[0]), 1);
      send_frame(8'h00, 1, t);
      frm_vld = 1'b0;
      wait_done(0, bd, "t3_timeout");
      chk("t3_wr_cnt", 32'(wr_n - bw), 256);
      chk("t3_all_wr", 32'(count_bad(bw, 256)), 0);
      chk("t3_len_sticky", 32'(elen[0]), 1);
      chk("t3_cks", 32'(ecks[0]), 0);
      send_byte(pay(0), 1'b1);
      frm_vld = 1'b0;
      chk("t3_len_clr", 32'(elen[0]), 0);

      // Readback corruption at 0x0C2 across RD_LAT 1..4
      do_reset();
      flip_en = 1'b1;
      for (int k = 0; k < 4; k++) bdk[k] = done_n[k];
      send_frame(8'h00, 0, t);
      frm_vld = 1'b0;
      for (int k = 0; k < 4; k++) wait_done(k, bdk[k], "t4_timeout");
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t4_vfy_lat%0d", k + 1), 32'(evfy[k]), VFY);
         chk($sformatf("t4_ecnt_lat%0d", k + 1), 32'(ecnt[k]), VFY);
         chk($sformatf("t4_done_lat%0d", k + 1), 32'(done_cyc[k] - t), VFY ? 2 * N + 3 + k : N + 2);
      end
      flip_en = 1'b0;

      // Reset during the 40th write cycle
      do_reset();
      bw = wr_n;
      send_frame(8'h00, 0, t);
      frm_vld = 1'b0;
      wc = 0;
      for (int w = 0; w < 2000 && wc < 40; w++) begin
         if (wren[0]) wc++;
         if (wc < 40) @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_wren_off", 32'(wren[0]), 0);
      chk("t5_busy_off", 32'(busy[0]), 0);
      chk("t5_rdy_rst", 32'(rdy[0]), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_rdy_rel", 32'(rdy[0]), 1);
      chk("t5_partial", 32'(wr_n - bw), 40);
      bw = wr_n; bd = done_n[0];
      send_frame(8'h00, 0, t);
      frm_vld = 1'b0;
      wait_done(0, bd, "t5_timeout");
      chk("t5_wr_cnt", 32'(wr_n - bw), 256);
      chk("t5_all_wr", 32'(count_bad(bw, 256)), 0);

      // Back-to-back frames with valid held high: second SOP waits for IDLE
      do_reset();
      bw = wr_n; bd = done_n[0];
      send_frame(8'h00, 0, t);
      send_frame(8'h00, 0, tb2);
      frm_vld = 1'b0;
      wait_done(0, bd + 1, "t6_timeout");
      chk("t6_done_a", 32'(done_log[bd % 64] - t), VFY ? 2 * N + 3 : N + 2);
      chk("t6_b_sop_acc", 32'(first_acc - done_log[bd % 64]), 1);
      chk("t6_wr_cnt", 32'(wr_n - bw), 512);
      chk("t6_all_wr", 32'(count_bad(bw, 512)), 0);
      chk("t6_done_b", 32'(done_cyc[0] - tb2), VFY ? 2 * N + 3 : N + 2);

      chk("overlap", 32'(ovl_n), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
